fetch_stage: RTL

Instruction-fetch stage feeding the decode/execute pipeline. Owns the PC, drives the synchronous instruction memory, and presents one instruction per cycle to decode. Obeys the hazard controller's `pc_delay`, `noop` and `stall` controls, and applies branch/jump redirects from execute. Buffers the in-flight fetch across holds, so no instruction is lost or duplicated.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_hold_buf.sv | 44 ++++
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM states, bubble encoding and default boot address.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_KILL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Capture/hold register pair for the instruction in flight when the fetch stage is held.
module fetch_hold_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         capture_i,
    input  logic         release_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         vld_o
);

    logic [W-1:0] data_q, data_d;
    logic         vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (capture_i) begin
            data_d = data_i;
            vld_d  = 1'b1;
        end else if (release_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives synchronous imem, applies hazard holds and redirects.
// Optional FETCH_PERF_CNT_EN adds hold-cycle and kill-entry performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_delay,
    input  logic        noop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_re,
    input  logic [31:0] imem_dout,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_hold_cycles,
    output logic [31:0] perf_kill_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  pc_d_q, pc_d_d;
    logic         redir_pend_q, redir_pend_d;
    logic [31:0]  redir_pc_q, redir_pc_d;

    logic         hb_capture, hb_release, hb_flush;
    logic [31:0]  hold_inst;
    logic         hold_vld;

    logic [31:0]  redirect_tgt;
    logic         unused_redirect_lsbs;

    assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    fetch_hold_buf #(.W(32)) u_hold_buf (
        .clk_i     (clk),
        .rst_i     (rst),
        .capture_i (hb_capture),
        .release_i (hb_release),
        .flush_i   (hb_flush),
        .data_i    (imem_dout),
        .data_o    (hold_inst),
        .vld_o     (hold_vld)
    );

    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        pc_d_d       = pc_d_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        hb_capture   = 1'b0;
        hb_release   = 1'b0;
        hb_flush     = 1'b0;

        if (stall) begin
            // Stalled redirects are parked; the newest target wins.
            if (redirect) begin
                redir_pend_d = 1'b1;
                redir_pc_d   = redirect_tgt;
            end
            if (state_q == S_RUN) begin
                state_d    = S_HOLD;
                hb_capture = !hold_vld;
            end
        end else if (redirect || redir_pend_q) begin
            pc_f_d       = redirect ? redirect_tgt : redir_pc_q;
            state_d      = S_KILL;
            hb_flush     = 1'b1;
            redir_pend_d = 1'b0;
        end else if (pc_delay) begin
            if (state_q == S_RUN) begin
                state_d    = S_HOLD;
                hb_capture = !hold_vld;
            end
        end else begin
            case (state_q)
                S_HOLD: begin
                    // A bubble on the release cycle must not consume the held instruction.
                    // imem_re was low while held, so imem_dout still carries the pc_f word.
                    if (!noop) begin
                        state_d    = S_RUN;
                        pc_d_d     = pc_f_q;
                        pc_f_d     = pc_f_q + 32'd4;
                        hb_release = 1'b1;
                    end
                end
                default: begin
                    state_d = S_RUN;
                    pc_d_d  = pc_f_q;
                    pc_f_d  = pc_f_q + 32'd4;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_f_q       <= RESET_PC;
            pc_d_q       <= '0;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            pc_d_q       <= pc_d_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
        end
    end

    assign imem_addr = pc_f_q;
    assign imem_re   = !rst && (state_q != S_HOLD);

    always_comb begin
        inst_out   = NOP_INST;
        inst_valid = 1'b0;
        pc_out     = pc_d_q;
        case (state_q)
            S_RUN: begin
                inst_out   = imem_dout;
                inst_valid = 1'b1;
            end
            S_HOLD: begin
                if (hold_vld) begin
                    inst_out   = hold_inst;
                    inst_valid = 1'b1;
                end
            end
            default: ;
        endcase
        if (noop && !stall) begin
            inst_out   = NOP_INST;
            inst_valid = 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] hold_cnt_q, kill_cnt_q;
    logic        kill_entry;

    assign kill_entry = !stall && (redirect || redir_pend_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            kill_cnt_q <= '0;
        end else begin
            if (state_q == S_HOLD) hold_cnt_q <= hold_cnt_q + 32'd1;
            if (kill_entry)        kill_cnt_q <= kill_cnt_q + 32'd1;
        end
    end

    assign perf_hold_cycles = hold_cnt_q;
    assign perf_kill_cnt    = kill_cnt_q;
`endif

endmodule
